// File: rtl/set_scan_ctrl_pkg.sv
// Shared definitions for the set-coverage scan controller: bus field sizes,
// covered-bit positions, set-mode encodings and lane helpers.
package set_scan_ctrl_pkg;

    localparam int COORD_SZ   = 8;
    localparam int CENTRAL_SZ = 24;
    localparam int RADIUS_SZ  = 12;
    localparam int COVERED_SZ = 3;

    // Bit positions inside one lane of covered_i, lane = {A,B,C}
    localparam int COV_A = 2;
    localparam int COV_B = 1;
    localparam int COV_C = 0;

    typedef enum logic [1:0] {
        MODE_A   = 2'b00,
        MODE_AND = 2'b01,
        MODE_XOR = 2'b10,
        MODE_TWO = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic [COORD_SZ-1:0] pack_coord(input logic [3:0] x, input logic [3:0] y);
        return {x, y};
    endfunction

    function automatic logic set_sel(input mode_e mode, input logic [COVERED_SZ-1:0] cov);
        logic a, b, c;
        a = cov[COV_A];
        b = cov[COV_B];
        c = cov[COV_C];
        case (mode)
            MODE_A:   return a;
            MODE_AND: return a & b;
            MODE_XOR: return a ^ b;
            default:  return (a & b & ~c) | (a & ~b & c) | (~a & b & c);
        endcase
    endfunction

endpackage

// File: rtl/set_scan_ctrl_if.sv
// Job/PE bus of the scan controller. The slave side is the controller itself,
// the master side is the host plus the PE array.
interface set_scan_ctrl_if #(
    parameter int NUM_PE = 8,
    parameter int CNT_W  = 7
);
    import set_scan_ctrl_pkg::*;

    logic                               en_i;
    logic [CENTRAL_SZ-1:0]              central_i;
    logic [RADIUS_SZ-1:0]               radius_i;
    logic [1:0]                         mode_i;
    logic [NUM_PE*COVERED_SZ-1:0]       covered_i;
    logic                               busy_o;
    logic                               valid_o;
    logic [CNT_W-1:0]                   candidate_o;
    logic [NUM_PE*COORD_SZ-1:0]         coord_o;
    logic [CENTRAL_SZ-1:0]              cent_buf_o;
    logic [RADIUS_SZ-1:0]               r_buf_o;

    modport master (
        output en_i, central_i, radius_i, mode_i, covered_i,
        input  busy_o, valid_o, candidate_o, coord_o, cent_buf_o, r_buf_o
    );

    modport slave (
        input  en_i, central_i, radius_i, mode_i, covered_i,
        output busy_o, valid_o, candidate_o, coord_o, cent_buf_o, r_buf_o
    );

endinterface

// File: rtl/set_scan_ctrl_popcount.sv
// Combinational count of PE lanes whose covered bits satisfy the set expression.
module set_scan_ctrl_popcount
    import set_scan_ctrl_pkg::*;
#(
    parameter int NUM_PE = 8
) (
    input  logic [NUM_PE*COVERED_SZ-1:0]  covered,
    input  mode_e                         mode,
    output logic [$clog2(NUM_PE+1)-1:0]   count
);

    localparam int PC_W = $clog2(NUM_PE + 1);

    always_comb begin
        count = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            count = count + PC_W'(set_sel(mode, covered[k*COVERED_SZ +: COVERED_SZ]));
        end
    end

endmodule

// File: rtl/set_scan_ctrl.sv
// Scan controller: walks the GRIDxGRID lattice NUM_PE points per cycle and
// accumulates how many points satisfy the selected set expression.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for en_i; job inputs captured on acceptance
//   ST_SCAN | STEPS cycles driving lane coords, accumulating PE results
//   ST_DONE | one cycle, valid_o pulses with the final count
module set_scan_ctrl
    import set_scan_ctrl_pkg::*;
#(
    parameter int NUM_PE = 8,
    parameter int GRID   = 8,
    parameter int CNT_W  = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    set_scan_ctrl_if.slave  bus
);

    localparam int STEPS  = GRID * GRID / NUM_PE;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PC_W   = $clog2(NUM_PE + 1);

    state_e                      state, state_nxt;
    logic [STEP_W-1:0]           step;
    logic [CNT_W-1:0]            acc;
    logic [CNT_W-1:0]            cand_q;
    logic [CENTRAL_SZ-1:0]       cent_q;
    logic [RADIUS_SZ-1:0]        rad_q;
    mode_e                       mode_q;
    logic [PC_W-1:0]             pop;
    logic                        last_step;
    logic [NUM_PE*COORD_SZ-1:0]  coord;
    int                          idx;

    assign last_step = (step == STEP_W'(STEPS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.busy_o  = 1'b1;
        bus.valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.busy_o = 1'b0;
                if (bus.en_i) state_nxt = ST_SCAN;
            end
            ST_SCAN: if (last_step) state_nxt = ST_DONE;
            ST_DONE: begin
                bus.valid_o = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: begin
                bus.busy_o = 1'b0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    // The final count is latched on the last scan step so candidate_o holds
    // across idle periods until the next job completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step   <= '0;
            acc    <= '0;
            cand_q <= '0;
            cent_q <= '0;
            rad_q  <= '0;
            mode_q <= MODE_A;
        end else begin
            case (state)
                ST_IDLE: if (bus.en_i) begin
                    cent_q <= bus.central_i;
                    rad_q  <= bus.radius_i;
                    mode_q <= mode_e'(bus.mode_i);
                    acc    <= '0;
                    step   <= '0;
                end
                ST_SCAN: begin
                    acc  <= acc + CNT_W'(pop);
                    step <= step + STEP_W'(1);
                    if (last_step) cand_q <= acc + CNT_W'(pop);
                end
                default: ;
            endcase
        end
    end

    // Lane k of step s covers lattice index s*NUM_PE+k, row-major from (1,1).
    always_comb begin
        coord = '0;
        idx   = 0;
        if (state == ST_SCAN) begin
            for (int k = 0; k < NUM_PE; k++) begin
                idx = int'(step) * NUM_PE + k;
                coord[k*COORD_SZ +: COORD_SZ] = pack_coord(4'(idx % GRID + 1), 4'(idx / GRID + 1));
            end
        end
    end

    set_scan_ctrl_popcount #(.NUM_PE(NUM_PE)) u_popcount (
        .covered (bus.covered_i),
        .mode    (mode_q),
        .count   (pop)
    );

    assign bus.coord_o     = coord;
    assign bus.candidate_o = cand_q;
    assign bus.cent_buf_o  = cent_q;
    assign bus.r_buf_o     = rad_q;

endmodule
